// File: rtl/bolme_paket.sv
// bolme_paket: states, opcode encodings and shared constants for the
// divider client (bolme_istemcisi).
package bolme_paket;

    typedef enum logic [2:0] {
        BOS    = 3'd0,
        GONDER = 3'd1,
        BEKLE  = 3'd2,
        IPTAL  = 3'd3,
        YAZ    = 3'd4
    } durum_t;

    localparam logic [3:0] ISLEV_DIV  = 4'b0001;
    localparam logic [3:0] ISLEV_DIVU = 4'b0010;
    localparam logic [3:0] ISLEV_REM  = 4'b0100;
    localparam logic [3:0] ISLEV_REMU = 4'b1000;

    localparam logic [31:0] ZAMAN_ASIMI_VERI = 32'hFFFF_FFFF;

    // Only the four single-bit encodings are legal divider opcodes.
    function automatic logic tek_sicak(input logic [3:0] kod);
        return (kod == ISLEV_DIV) || (kod == ISLEV_DIVU) ||
               (kod == ISLEV_REM) || (kod == ISLEV_REMU);
    endfunction

endpackage

// File: rtl/bolme_sonuc_onbellegi.sv
// bolme_sonuc_onbellegi: single-entry last-result cache for the divider
// client. Only instantiated when BOLME_ISTEMCISI_ONBELLEK_EN is defined.
module bolme_sonuc_onbellegi (
    input  logic        clk_g,
    input  logic        rst_g,
    input  logic        yaz_en,
    input  logic        sil,
    input  logic [3:0]  yaz_islev_kodu,
    input  logic [31:0] yaz_islec1,
    input  logic [31:0] yaz_islec2,
    input  logic [31:0] yaz_sonuc,
    input  logic [3:0]  sor_islev_kodu,
    input  logic [31:0] sor_islec1,
    input  logic [31:0] sor_islec2,
    output logic        isabet,
    output logic [31:0] sonuc
);

    logic        gecerli;
    logic [3:0]  islev_r;
    logic [31:0] islec1_r;
    logic [31:0] islec2_r;
    logic [31:0] sonuc_r;

    // Invalidate wins over a same-cycle store so a cancelled result never lingers.
    always_ff @(posedge clk_g or negedge rst_g) begin
        if (!rst_g) begin
            gecerli  <= 1'b0;
            islev_r  <= '0;
            islec1_r <= '0;
            islec2_r <= '0;
            sonuc_r  <= '0;
        end else if (sil) begin
            gecerli <= 1'b0;
        end else if (yaz_en) begin
            gecerli  <= 1'b1;
            islev_r  <= yaz_islev_kodu;
            islec1_r <= yaz_islec1;
            islec2_r <= yaz_islec2;
            sonuc_r  <= yaz_sonuc;
        end
    end

    // Lookup compares against the live request fields, not the latched ones.
    always_comb begin
        isabet = gecerli && (islev_r == sor_islev_kodu) &&
                 (islec1_r == sor_islec1) && (islec2_r == sor_islec2);
        sonuc  = sonuc_r;
    end

endmodule

// File: rtl/bolme_istemcisi.sv
// bolme_istemcisi: accepts a divide/remainder request from the core,
// starts the external divider, waits for its result with a timeout and
// hands the result back through a writeback handshake.
// Optional: BOLME_ISTEMCISI_ONBELLEK_EN adds a last-result cache.
//
// state  | meaning
// BOS    | idle, istek_hazir_c high, waiting for a request
// GONDER | one-cycle start pulse to the divider
// BEKLE  | waiting for divider done, timeout counter running
// IPTAL  | cancelled; draining the divider's done (or timeout), no writeback
// YAZ    | holding writeback until yaz_hazir_g
import bolme_paket::*;

module bolme_istemcisi #(
    parameter int unsigned ZAMAN_ASIMI = 80
) (
    input  logic        clk_g,
    input  logic        rst_g,
    input  logic        istek_gecerli_g,
    output logic        istek_hazir_c,
    input  logic [3:0]  islev_kodu_g,
    input  logic [31:0] islec1_g,
    input  logic [31:0] islec2_g,
    input  logic [4:0]  hedef_g,
    input  logic        iptal_g,
    output logic        bolucu_hazir_c,
    output logic [3:0]  bolucu_islev_kodu_c,
    output logic [31:0] bolucu_islec1_c,
    output logic [31:0] bolucu_islec2_c,
    input  logic        bolucu_bitti_g,
    input  logic [31:0] bolucu_sonuc_g,
    output logic        yaz_gecerli_c,
    output logic [4:0]  yaz_hedef_c,
    output logic [31:0] yaz_veri_c,
    input  logic        yaz_hazir_g,
    output logic        hata_c
);

    localparam logic [7:0] SON_SAYI = 8'(ZAMAN_ASIMI - 1);

    durum_t      durum;
    logic [7:0]  sayac;
    logic [4:0]  hedef_r;
    logic        zaman_doldu;
    logic        bos_don;
    logic        istek_isabet;
    logic [31:0] isabet_sonuc;

    // Every path that ends the transaction without a (further) writeback.
    always_comb begin
        zaman_doldu = (sayac >= SON_SAYI);
        bos_don     = ((durum == BEKLE) && iptal_g && bolucu_bitti_g) ||
                      ((durum == IPTAL) && (bolucu_bitti_g || zaman_doldu)) ||
                      ((durum == YAZ) && (iptal_g || yaz_hazir_g));
    end

`ifdef BOLME_ISTEMCISI_ONBELLEK_EN
    logic onb_yaz;
    logic onb_sil;

    // Store on a clean capture; drop on timeout or any effective cancel.
    always_comb begin
        onb_yaz = (durum == BEKLE) && bolucu_bitti_g && !iptal_g;
        onb_sil = ((durum == BEKLE) && !bolucu_bitti_g && zaman_doldu) ||
                  (iptal_g && (durum != BOS));
    end

    bolme_sonuc_onbellegi u_onbellek (
        .clk_g          (clk_g),
        .rst_g          (rst_g),
        .yaz_en         (onb_yaz),
        .sil            (onb_sil),
        .yaz_islev_kodu (bolucu_islev_kodu_c),
        .yaz_islec1     (bolucu_islec1_c),
        .yaz_islec2     (bolucu_islec2_c),
        .yaz_sonuc      (bolucu_sonuc_g),
        .sor_islev_kodu (islev_kodu_g),
        .sor_islec1     (islec1_g),
        .sor_islec2     (islec2_g),
        .isabet         (istek_isabet),
        .sonuc          (isabet_sonuc)
    );
`else
    assign istek_isabet = 1'b0;
    assign isabet_sonuc = '0;
`endif

    // Main controller; all outputs are registered here.
    always_ff @(posedge clk_g or negedge rst_g) begin
        if (!rst_g) begin
            durum               <= BOS;
            sayac               <= '0;
            hedef_r             <= '0;
            istek_hazir_c       <= 1'b1;
            bolucu_hazir_c      <= 1'b0;
            bolucu_islev_kodu_c <= '0;
            bolucu_islec1_c     <= '0;
            bolucu_islec2_c     <= '0;
            yaz_gecerli_c       <= 1'b0;
            yaz_hedef_c         <= '0;
            yaz_veri_c          <= '0;
            hata_c              <= 1'b0;
        end else begin
            bolucu_hazir_c <= 1'b0;
            hata_c         <= 1'b0;
            case (durum)
                BOS: begin
                    if (istek_gecerli_g) begin
                        istek_hazir_c       <= 1'b0;
                        bolucu_islev_kodu_c <= islev_kodu_g;
                        bolucu_islec1_c     <= islec1_g;
                        bolucu_islec2_c     <= islec2_g;
                        hedef_r             <= hedef_g;
                        if (!tek_sicak(islev_kodu_g)) begin
                            yaz_gecerli_c <= 1'b1;
                            yaz_hedef_c   <= hedef_g;
                            yaz_veri_c    <= '0;
                            durum         <= YAZ;
                        end else if (istek_isabet) begin
                            yaz_gecerli_c <= 1'b1;
                            yaz_hedef_c   <= hedef_g;
                            yaz_veri_c    <= isabet_sonuc;
                            durum         <= YAZ;
                        end else begin
                            bolucu_hazir_c <= 1'b1;
                            durum          <= GONDER;
                        end
                    end
                end
                GONDER: begin
                    sayac <= '0;
                    durum <= iptal_g ? IPTAL : BEKLE;
                end
                BEKLE: begin
                    if (iptal_g) begin
                        // Same-cycle done is discarded via bos_don below.
                        durum <= IPTAL;
                        if (!zaman_doldu) sayac <= sayac + 8'd1;
                    end else if (bolucu_bitti_g) begin
                        yaz_gecerli_c <= 1'b1;
                        yaz_hedef_c   <= hedef_r;
                        yaz_veri_c    <= bolucu_sonuc_g;
                        durum         <= YAZ;
                    end else if (zaman_doldu) begin
                        hata_c        <= 1'b1;
                        yaz_gecerli_c <= 1'b1;
                        yaz_hedef_c   <= hedef_r;
                        yaz_veri_c    <= ZAMAN_ASIMI_VERI;
                        durum         <= YAZ;
                    end else begin
                        sayac <= sayac + 8'd1;
                    end
                end
                IPTAL: begin
                    if (!zaman_doldu) sayac <= sayac + 8'd1;
                end
                YAZ: begin
                end
                default: durum <= BOS;
            endcase

            if (bos_don) begin
                durum               <= BOS;
                istek_hazir_c       <= 1'b1;
                bolucu_islev_kodu_c <= '0;
                bolucu_islec1_c     <= '0;
                bolucu_islec2_c     <= '0;
                yaz_gecerli_c       <= 1'b0;
                yaz_hedef_c         <= '0;
                yaz_veri_c          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bolme_istemcisi.sv
// tb_bolme_istemcisi: self-checking bench for bolme_istemcisi with a
// behavioural divider and a writeback scoreboard.
module tb_bolme_istemcisi;

    logic        clk_g = 1'b0;
    logic        rst_g = 1'b0;
    logic        istek_gecerli_g = 1'b0;
    logic        istek_hazir_c;
    logic [3:0]  islev_kodu_g = '0;
    logic [31:0] islec1_g = '0;
    logic [31:0] islec2_g = '0;
    logic [4:0]  hedef_g = '0;
    logic        iptal_g = 1'b0;
    logic        bolucu_hazir_c;
    logic [3:0]  bolucu_islev_kodu_c;
    logic [31:0] bolucu_islec1_c;
    logic [31:0] bolucu_islec2_c;
    logic        bolucu_bitti_g;
    logic [31:0] bolucu_sonuc_g;
    logic        yaz_gecerli_c;
    logic [4:0]  yaz_hedef_c;
    logic [31:0] yaz_veri_c;
    logic        yaz_hazir_g = 1'b1;
    logic        hata_c;

    logic        dv_done = 1'b0;
    logic [31:0] dv_sonuc = '0;
    logic        man_done = 1'b0;
    logic [31:0] man_sonuc = '0;
    assign bolucu_bitti_g = dv_done | man_done;
    assign bolucu_sonuc_g = man_done ? man_sonuc : dv_sonuc;

    always #5 clk_g = ~clk_g;

    bolme_istemcisi #(.ZAMAN_ASIMI(80)) dut (
        .clk_g(clk_g), .rst_g(rst_g),
        .istek_gecerli_g(istek_gecerli_g), .istek_hazir_c(istek_hazir_c),
        .islev_kodu_g(islev_kodu_g), .islec1_g(islec1_g), .islec2_g(islec2_g),
        .hedef_g(hedef_g), .iptal_g(iptal_g),
        .bolucu_hazir_c(bolucu_hazir_c), .bolucu_islev_kodu_c(bolucu_islev_kodu_c),
        .bolucu_islec1_c(bolucu_islec1_c), .bolucu_islec2_c(bolucu_islec2_c),
        .bolucu_bitti_g(bolucu_bitti_g), .bolucu_sonuc_g(bolucu_sonuc_g),
        .yaz_gecerli_c(yaz_gecerli_c), .yaz_hedef_c(yaz_hedef_c),
        .yaz_veri_c(yaz_veri_c), .yaz_hazir_g(yaz_hazir_g), .hata_c(hata_c)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
        int          pulses;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        int          acc;
        int          lat;
    } sb_t;

    sb_t         sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          hata_cnt = 0;
    int          dv_lat = 4;
    bit          dv_mute = 1'b0;
    logic [3:0]  last_op = '0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    bit          in_wb = 1'b0;
    int          wb_len = 0;
    int          last_wb_len = 0;
    logic [31:0] held_veri = '0;
    logic [4:0]  held_hedef = '0;

    always @(posedge clk_g) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            4'h1:    return 32'(sa / sb);
            4'h2:    return a / b;
            4'h4:    return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    // Behavioural divider: done is sampled dv_lat cycles after the start pulse.
    initial begin
        logic [31:0] r;
        forever begin
            @(negedge clk_g);
            if (bolucu_hazir_c && rst_g && !dv_mute) begin
                r = ref_div(bolucu_islev_kodu_c, bolucu_islec1_c, bolucu_islec2_c);
                repeat (dv_lat) @(posedge clk_g);
                #1 dv_done = 1'b1;
                dv_sonuc = r;
                @(posedge clk_g);
                #1 dv_done = 1'b0;
            end
        end
    end

    // Monitor: divider pulses, hata pulses, writeback scoreboard and stability.
    always @(negedge clk_g) begin
        if (!rst_g) begin
            in_wb = 1'b0;
        end else begin
            if (bolucu_hazir_c) begin
                pulse_cnt++;
                check("bolucu_islev", {28'b0, bolucu_islev_kodu_c}, {28'b0, last_op});
                check("bolucu_islec1", bolucu_islec1_c, last_a);
                check("bolucu_islec2", bolucu_islec2_c, last_b);
            end
            if (hata_c) begin
                hata_cnt++;
                check("hata_with_wb", {31'b0, yaz_gecerli_c}, 32'd1);
                check("hata_veri", yaz_veri_c, 32'hFFFF_FFFF);
            end
            if (yaz_gecerli_c) begin
                if (!in_wb) begin
                    in_wb = 1'b1;
                    wb_len = 0;
                    held_veri = yaz_veri_c;
                    held_hedef = yaz_hedef_c;
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_wb actual=tag %0d data %h required=none",
                                 yaz_hedef_c, yaz_veri_c);
                    end else begin
                        check("wb_tag", {27'b0, yaz_hedef_c}, {27'b0, sbq[0].tag});
                        check("wb_data", yaz_veri_c, sbq[0].data);
                        check("wb_latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                    end
                end else begin
                    check("wb_stable_veri", yaz_veri_c, held_veri);
                    check("wb_stable_tag", {27'b0, yaz_hedef_c}, {27'b0, held_hedef});
                end
                wb_len++;
                if (yaz_hazir_g) begin
                    in_wb = 1'b0;
                    last_wb_len = wb_len;
                    if (sbq.size() != 0) void'(sbq.pop_front());
                end
            end else begin
                in_wb = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input bit wb, input logic [31:0] exp,
                          input int lat);
        int n;
        n = 0;
        @(posedge clk_g); #1;
        while (!istek_hazir_c && n < 400) begin
            @(posedge clk_g); #1;
            n++;
        end
        check("req_ready", {31'b0, istek_hazir_c}, 32'd1);
        istek_gecerli_g = 1'b1;
        islev_kodu_g = op;
        islec1_g = a;
        islec2_g = b;
        hedef_g = tag;
        last_op = op;
        last_a = a;
        last_b = b;
        if (wb) sbq.push_back('{tag: tag, data: exp, acc: cyc, lat: lat});
        @(posedge clk_g); #1;
        istek_gecerli_g = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sbq.size() == 0 && istek_hazir_c && !yaz_gecerli_c) && n < 400) begin
            @(posedge clk_g); #1;
            n++;
        end
        check("idle_reached", {31'b0, (n < 400)}, 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        int p0;
        int h0;
        int n;

        vecs[0] = '{4'h1, 32'd100,        32'd7,  5'd5,  32'd14,         17, 1};
        vecs[1] = '{4'h2, 32'hFFFF_FFF0,  32'd3,  5'd1,  32'h5555_5550,  4,  1};
        vecs[2] = '{4'h8, 32'd1000,       32'd33, 5'd2,  32'd10,         1,  1};
        vecs[3] = '{4'h1, 32'hFFFF_FFEC,  32'd3,  5'd31, 32'hFFFF_FFFA,  9,  1};
        vecs[4] = '{4'h3, 32'd8,          32'd2,  5'd7,  32'd0,          4,  0};
        vecs[5] = '{4'h0, 32'd9,          32'd3,  5'd3,  32'd0,          4,  0};
        vecs[6] = '{4'hF, 32'd12,         32'd4,  5'd9,  32'd0,          4,  0};

        // Reset state
        #12;
        check("rst_istek_hazir", {31'b0, istek_hazir_c}, 32'd1);
        check("rst_yaz_gecerli", {31'b0, yaz_gecerli_c}, 32'd0);
        check("rst_bolucu_hazir", {31'b0, bolucu_hazir_c}, 32'd0);
        check("rst_hata", {31'b0, hata_c}, 32'd0);
        check("rst_yaz_veri", yaz_veri_c, 32'd0);
        @(posedge clk_g); #1 rst_g = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            dv_lat = vecs[i].lat;
            p0 = pulse_cnt;
            do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, vecs[i].exp,
                   (vecs[i].pulses != 0) ? vecs[i].lat + 2 : 1);
            wait_idle();
            check($sformatf("pulses_vec%0d", i), 32'(pulse_cnt - p0), 32'(vecs[i].pulses));
        end

        // REM with writeback stalled for 3 cycles
        dv_lat = 5;
        yaz_hazir_g = 1'b0;
        do_req(4'h4, 32'hFFFF_FFF9, 32'd2, 5'd12, 1'b1, 32'hFFFF_FFFF, 7);
        n = 0;
        while (!yaz_gecerli_c && n < 200) begin
            @(posedge clk_g); #1;
            n++;
        end
        check("rem_wb_seen", {31'b0, yaz_gecerli_c}, 32'd1);
        repeat (3) begin
            @(posedge clk_g); #1;
        end
        yaz_hazir_g = 1'b1;
        wait_idle();
        check("rem_wb_len", 32'(last_wb_len), 32'd4);

        // Timeout: no done within 80 BEKLE cycles
        dv_mute = 1'b1;
        p0 = pulse_cnt;
        h0 = hata_cnt;
        do_req(4'h1, 32'd5, 32'd1, 5'd11, 1'b1, 32'hFFFF_FFFF, 82);
        wait_idle();
        check("timeout_hata_pulses", 32'(hata_cnt - h0), 32'd1);
        check("timeout_div_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Cancel in BEKLE, done 5 cycles later with result 9
        h0 = hata_cnt;
        do_req(4'h2, 32'd81, 32'd9, 5'd13, 1'b0, 32'd0, 0);
        repeat (3) begin
            @(posedge clk_g); #1;
        end
        iptal_g = 1'b1;
        @(posedge clk_g); #1 iptal_g = 1'b0;
        repeat (4) begin
            @(posedge clk_g); #1;
        end
        check("iptal_wait_busy", {31'b0, istek_hazir_c}, 32'd0);
        man_done = 1'b1;
        man_sonuc = 32'd9;
        @(posedge clk_g); #1 man_done = 1'b0;
        check("iptal_ready_after_done", {31'b0, istek_hazir_c}, 32'd1);
        check("iptal_no_hata", 32'(hata_cnt - h0), 32'd0);

        // Cancel and done in the same BEKLE cycle: cancel wins
        do_req(4'h8, 32'd77, 32'd10, 5'd14, 1'b0, 32'd0, 0);
        @(posedge clk_g); #1;
        iptal_g = 1'b1;
        man_done = 1'b1;
        man_sonuc = 32'd7;
        @(posedge clk_g); #1;
        iptal_g = 1'b0;
        man_done = 1'b0;
        check("iptal_done_same_ready", {31'b0, istek_hazir_c}, 32'd1);

        // Stray done while idle is ignored
        man_done = 1'b1;
        @(posedge clk_g); #1 man_done = 1'b0;
        @(posedge clk_g); #1;
        check("stray_done_no_wb", {31'b0, yaz_gecerli_c}, 32'd0);
        dv_mute = 1'b0;

        // DIVU 50/5 issued twice
        dv_lat = 4;
        p0 = pulse_cnt;
        do_req(4'h2, 32'd50, 32'd5, 5'd6, 1'b1, 32'd10, 6);
        wait_idle();
        check("divu_first_pulses", 32'(pulse_cnt - p0), 32'd1);
        p0 = pulse_cnt;
`ifdef BOLME_ISTEMCISI_ONBELLEK_EN
        do_req(4'h2, 32'd50, 32'd5, 5'd8, 1'b1, 32'd10, 1);
        wait_idle();
        check("divu_second_pulses", 32'(pulse_cnt - p0), 32'd0);
`else
        do_req(4'h2, 32'd50, 32'd5, 5'd8, 1'b1, 32'd10, 6);
        wait_idle();
        check("divu_second_pulses", 32'(pulse_cnt - p0), 32'd1);
`endif

        // Reset in the middle of BEKLE
        dv_mute = 1'b1;
        do_req(4'h2, 32'd7, 32'd1, 5'd15, 1'b0, 32'd0, 0);
        repeat (4) begin
            @(posedge clk_g); #1;
        end
        rst_g = 1'b0;
        #1;
        check("midrst_istek_hazir", {31'b0, istek_hazir_c}, 32'd1);
        check("midrst_islec1", bolucu_islec1_c, 32'd0);
        check("midrst_islev", {28'b0, bolucu_islev_kodu_c}, 32'd0);
        check("midrst_yaz_gecerli", {31'b0, yaz_gecerli_c}, 32'd0);
        @(posedge clk_g); #1 rst_g = 1'b1;
        dv_mute = 1'b0;
        p0 = pulse_cnt;
        do_req(4'h2, 32'd50, 32'd5, 5'd4, 1'b1, 32'd10, 6);
        wait_idle();
        check("post_rst_pulses", 32'(pulse_cnt - p0), 32'd1);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
